alu_mdu_control: RTL and testbench

Parametrised successor to the datapath ALU-operation decoder. It maps the control-unit op class (ula_op) and the R-type funct field to the ALU selector, covering the extended op set (or, nor, slt, ori, slti). It adds an iterative multiply/divide unit (MDU) for mult/multu/div/divu with a start/busy/done handshake and HI/LO registers. It sits between the main control FSM, the register-file read ports and the ALU.

---
 rtl/alu_mdu_control_pkg.sv | 53 +++++
 rtl/alu_mdu_control_if.sv | 27 ++
 rtl/alu_mdu_control_mdu_iter.sv | 61 ++++++
 rtl/alu_mdu_control.sv | 121 ++++++++++++
 tb/tb_alu_mdu_control.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_control_pkg.sv
// Shared types for the ALU selector decode and the iterative multiply/divide unit.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
        OP_OR   = 3'b100, OP_NOR = 3'b101, OP_XOR = 3'b110, OP_SLT = 3'b111
    } opsel_t;

    typedef enum logic [2:0] {
        ULA_PC4  = 3'b000, ULA_BRANCH = 3'b001, ULA_RTYPE = 3'b010, ULA_ANDI = 3'b011,
        ULA_XORI = 3'b100, ULA_ORI    = 3'b101, ULA_SLTI  = 3'b110, ULA_PASS = 3'b111
    } ula_op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU  = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR    = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU  = 6'h2B;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic opsel_t decode_sel(input logic [2:0] ula_op, input logic [5:0] funct);
        opsel_t s;
        s = OP_ADD;
        case (ula_op_t'(ula_op))
            ULA_PC4:    s = OP_ADD;
            ULA_BRANCH: s = OP_SUB;
            ULA_ANDI:   s = OP_AND;
            ULA_XORI:   s = OP_XOR;
            ULA_ORI:    s = OP_OR;
            ULA_SLTI:   s = OP_SLT;
            ULA_PASS:   s = OP_PASS;
            ULA_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: s = OP_ADD;
                    F_SUB, F_SUBU: s = OP_SUB;
                    F_AND:         s = OP_AND;
                    F_OR:          s = OP_OR;
                    F_XOR:         s = OP_XOR;
                    F_NOR:         s = OP_NOR;
                    F_SLT, F_SLTU: s = OP_SLT;
                    default:       s = OP_ADD;
                endcase
            end
            default:    s = OP_ADD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_mdu_control_if.sv
// Control/operand bus between the main control FSM, register file and the ALU/MDU control block.
interface alu_mdu_control_if #(
    parameter int WIDTH   = 32,
    parameter int OPSEL_W = 3
);
    logic [2:0]         ula_op;
    logic [5:0]         funct;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [OPSEL_W-1:0] ula_op_selector;
    logic               md_busy;
    logic               md_done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               div_by_zero;

    modport master (
        output ula_op, funct, start, a, b,
        input  ula_op_selector, md_busy, md_done, hi, lo, div_by_zero
    );

    modport slave (
        input  ula_op, funct, start, a, b,
        output ula_op_selector, md_busy, md_done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/alu_mdu_control_mdu_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) / divide (restoring) datapath on operand magnitudes.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_ma,
    input  logic [WIDTH-1:0] i_mb,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum, w_shift, w_trial;

    // mult: r_lo holds the multiplier and shifts out LSB-first; div: r_lo holds the dividend, becomes the quotient
    assign w_addend = r_lo[0] ? r_m : {WIDTH{1'b0}};
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_m};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_div <= i_is_div;
            r_m   <= i_is_div ? i_mb : i_ma;
            r_lo  <= i_is_div ? i_ma : i_mb;
            r_hi  <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_div) begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end else if (!w_trial[WIDTH]) begin
                r_hi <= w_trial[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                r_hi <= w_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/alu_mdu_control.sv
// ALU selector decode plus the mult/div handshake FSM, sign fix-up and HI/LO registers.
module alu_mdu_control
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPSEL_W = 3,
    parameter int REG_OUT = 1
) (
    input logic               clk,
    input logic               reset,
    alu_mdu_control_if.slave  bus
);
    mdu_state_t       r_state;
    logic             r_busy, r_done, r_dz, r_zero, r_is_div, r_neg_p, r_neg_r;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_signed, w_is_div, w_a_neg, w_b_neg, w_b_zero, w_accept, w_step, w_last;
    logic [WIDTH-1:0] w_ma, w_mb, w_it_hi, w_it_lo, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_prod;
    opsel_t           w_sel;

    assign w_sel = decode_sel(bus.ula_op, bus.funct);

    generate
        if (REG_OUT != 0) begin : g_sel_reg
            opsel_t r_sel;
            always_ff @(posedge clk) begin
                if (reset) r_sel <= OP_PASS;
                else       r_sel <= w_sel;
            end
            assign bus.ula_op_selector = OPSEL_W'(r_sel);
        end else begin : g_sel_comb
            assign bus.ula_op_selector = OPSEL_W'(w_sel);
        end
    endgenerate

    // funct[0]=0 selects the signed variant, funct[1]=1 selects divide
    assign w_signed = ~bus.funct[0];
    assign w_is_div = bus.funct[1];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_ma     = w_a_neg ? -bus.a : bus.a;
    assign w_mb     = w_b_neg ? -bus.b : bus.b;
    assign w_b_zero = (bus.b == '0);
    assign w_accept = bus.start && (bus.ula_op == ULA_RTYPE) && is_mdu_funct(bus.funct) && !r_busy;
    assign w_step   = (r_state == CALC);

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (w_is_div),
        .i_ma     (w_ma),
        .i_mb     (w_mb),
        .o_hi     (w_it_hi),
        .o_lo     (w_it_lo),
        .o_last   (w_last)
    );

    assign w_prod = r_neg_p ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};

    // On divide-by-zero the datapath never stepped, so its lo register still holds |a|
    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_zero) begin
            w_fix_hi = r_neg_r ? -w_it_lo : w_it_lo;
            w_fix_lo = '1;
        end else if (r_is_div) begin
            w_fix_hi = r_neg_r ? -w_it_hi : w_it_hi;
            w_fix_lo = r_neg_p ? -w_it_lo : w_it_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_zero   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CALC: if (w_last) r_state <= FIX;
                FIX: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_dz    <= r_zero;
                end
                default: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_state  <= (w_is_div && w_b_zero) ? FIX : CALC;
                        r_busy   <= 1'b1;
                        r_dz     <= 1'b0;
                        r_zero   <= w_is_div && w_b_zero;
                        r_is_div <= w_is_div;
                        r_neg_p  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                    end
                end
            endcase
        end
    end

    assign bus.md_busy     = r_busy;
    assign bus.md_done     = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_alu_mdu_control.sv
// Random + directed bench for alu_mdu_control: scoreboard of expected HI/LO results and completion times.
module tb_alu_mdu_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mdu_control_if #(.WIDTH(32), .OPSEL_W(3)) bus();

    alu_mdu_control #(.WIDTH(32), .OPSEL_W(3), .REG_OUT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0]     hi;
        logic [31:0]     lo;
        logic            dz;
        longint unsigned t_done;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [2:0] ref_sel(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return 3'b001;
            3'd1: return 3'b010;
            3'd3: return 3'b011;
            3'd4: return 3'b110;
            3'd5: return 3'b100;
            3'd6: return 3'b111;
            3'd7: return 3'b000;
            default: begin
                case (f)
                    6'h20, 6'h21: return 3'b001;
                    6'h22, 6'h23: return 3'b010;
                    6'h24:        return 3'b011;
                    6'h25:        return 3'b100;
                    6'h26:        return 3'b110;
                    6'h27:        return 3'b101;
                    6'h2A, 6'h2B: return 3'b111;
                    default:      return 3'b001;
                endcase
            end
        endcase
    endfunction

    // Full-width arithmetic reference; completion 33 cycles after acceptance, 1 for divide-by-zero
    function automatic exp_t ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     input longint unsigned t_acc);
        exp_t e;
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        e.dz = 1'b0;
        e.t_done = t_acc + 64'd335;
        case (f)
            6'h18: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            6'h19: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.t_done = t_acc + 64'd15;
                end else if (f == 6'h1A) begin
                    sp = sa / sb; e.lo = sp[31:0];
                    sp = sa % sb; e.hi = sp[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.md_done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: md_done at %0t with no pending op", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("hi", bus.hi, e.hi);
                    chk("lo", bus.lo, e.lo);
                    chk("div_by_zero", bus.div_by_zero, e.dz);
                    chk("done_time", $time, e.t_done);
                end
            end
        end
    end

    task automatic sel_check(input logic [2:0] op, input logic [5:0] f);
        bus.ula_op = op; bus.funct = f;
        @(negedge clk);
        chk("selector", bus.ula_op_selector, ref_sel(op, f));
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        bus.ula_op = 3'b010; bus.funct = f; bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(posedge clk);
        sbq.push_back(ref_mdu(f, av, bv, $time));
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", bus.md_busy, 1);
        chk("dz_clear_on_accept", bus.div_by_zero, 0);
    endtask

    // Optionally fires a stray start at cycle 'inject' of the running op; it must be ignored
    task automatic wait_done(input int inject);
        int cyc = 1;
        bit seen = 1'b0;
        while (!seen && cyc < 60) begin
            if (cyc == inject) begin
                bus.ula_op = 3'b010; bus.funct = 6'(6'h18 + $urandom_range(0, 3));
                bus.a = $urandom; bus.b = $urandom; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus.md_done) begin
                seen = 1'b1;
                chk("busy_low_at_done", bus.md_busy, 0);
            end else begin
                chk("busy_while_running", bus.md_busy, 1);
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: md_done not seen after %0d cycles, expected within 34", cyc);
        end
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] av, bv;
        int inj;
        reset = 1'b1; bus.start = 1'b0; bus.ula_op = 3'b000; bus.funct = 6'h00;
        bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_selector", bus.ula_op_selector, 0);
        chk("rst_busy", bus.md_busy, 0);
        chk("rst_done", bus.md_done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        reset = 1'b0;

        sel_check(3'b010, 6'h25);
        sel_check(3'b110, 6'h00);
        sel_check(3'b111, 6'h00);
        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(0, 1) == 1) ? 6'(6'h18 + $urandom_range(0, 19)) : 6'($urandom);
            sel_check(3'($urandom_range(0, 7)), f);
        end

        issue(6'h19, 32'hFFFF_FFFF, 32'd2);          wait_done(0);
        issue(6'h18, 32'hFFFF_FFFD, 32'd7);          wait_done(0);
        issue(6'h1A, 32'hFFFF_FFF9, 32'd2);          wait_done(0);
        issue(6'h1B, 32'd10, 32'd0);                 wait_done(0);
        issue(6'h1B, 32'd9, 32'd3);                  wait_done(0);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(0);
        issue(6'h18, 32'd123, 32'd456);              wait_done(4);

        @(negedge clk);
        bus.ula_op = 3'b010; bus.funct = 6'h20; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
        @(negedge clk);
        chk("nonmdu_start_ignored", bus.md_busy, 0);
        bus.ula_op = 3'b000; bus.funct = 6'h18;
        @(negedge clk);
        chk("non_rtype_start_ignored", bus.md_busy, 0);
        bus.start = 1'b0;

        issue(6'h1A, 32'd1000, 32'd7);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sbq.delete();
        chk("abort_busy", bus.md_busy, 0);
        chk("abort_done", bus.md_done, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_after_abort", bus.md_busy, 0);
        issue(6'h1B, 32'd100, 32'd7);                wait_done(0);

        for (int i = 0; i < 30; i++) begin
            f = 6'(6'h18 + $urandom_range(0, 3));
            av = $urandom; bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
                2: begin av = 32'($urandom_range(0, 50)); bv = 32'($urandom_range(1, 9)); end
                3: bv = 32'(-$signed(32'($urandom_range(1, 9))));
                default: ;
            endcase
            if (f[1] && bv == 32'd0) inj = 1;
            else inj = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 33);
            issue(f, av, bv);
            wait_done(inj);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
